// File: rtl/pc_pkg.sv
// Shared fetch-stage constants and types.
// The PC register, the incrementer and the return-address stack all use this package.
package pc_pkg;

  localparam int PC_ADDR_W = 11;
  localparam int RAS_DEPTH = 8;

  typedef logic [PC_ADDR_W-1:0] pc_addr_t;

endpackage

// File: rtl/pc_return_stack_if.sv
// Sequencer <-> return-address stack port bundle.
// The sequencer is the master. The stack is the slave.
interface pc_return_stack_if #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 8
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic              pop;
  logic              clr_err;
  logic [ADDR_W-1:0] top_addr;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, push_addr, pop, clr_err,
    input  top_addr, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, push_addr, pop, clr_err,
    output top_addr, empty, full, count, overflow, underflow
  );

endinterface

// File: rtl/pc_stack_ptr.sv
// Modulo-DEPTH up/down write pointer for the return stack.
// It also provides the index of the current top entry.
module pc_stack_ptr #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [PTR_W-1:0] wp,
  output logic [PTR_W-1:0] wp_m1
);

  logic [PTR_W-1:0] wp_q;
  logic [PTR_W-1:0] wp_d;

  // Next pointer: a simultaneous inc and dec cancel out. DEPTH is a power of two, so wrap is free.
  always_comb begin
    wp_d = wp_q;
    if (inc && !dec) begin
      wp_d = wp_q + PTR_W'(1);
    end else if (dec && !inc) begin
      wp_d = wp_q - PTR_W'(1);
    end else begin
      wp_d = wp_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= {PTR_W{1'b0}};
    end else begin
      wp_q <= wp_d;
    end
  end

  assign wp    = wp_q;
  assign wp_m1 = wp_q - PTR_W'(1);

endmodule

// File: rtl/pc_return_stack.sv
// Circular return-address LIFO for the PC sequencer.
// It provides occupancy status and sticky overflow/underflow flags.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W = PC_ADDR_W,
  parameter int DEPTH  = RAS_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  pc_return_stack_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              overflow_q;
  logic              overflow_d;
  logic              underflow_q;
  logic              underflow_d;

  logic [PTR_W-1:0]  wp_s;
  logic [PTR_W-1:0]  wp_m1_s;
  logic              ptr_inc_s;
  logic              ptr_dec_s;
  logic              wr_en_s;
  logic [PTR_W-1:0]  wr_idx_s;
  logic              ovf_set_s;
  logic              udf_set_s;
  logic              empty_s;
  logic              full_s;

  pc_stack_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (ptr_inc_s),
    .dec   (ptr_dec_s),
    .wp    (wp_s),
    .wp_m1 (wp_m1_s)
  );

  // Decode push/pop into pointer moves, write slot, count update and error events.
  always_comb begin
    empty_s   = (count_q == {CNT_W{1'b0}});
    full_s    = (count_q == CNT_W'(DEPTH));
    ptr_inc_s = 1'b0;
    ptr_dec_s = 1'b0;
    wr_en_s   = 1'b0;
    wr_idx_s  = wp_s;
    ovf_set_s = 1'b0;
    udf_set_s = 1'b0;
    count_d   = count_q;
    case ({bus.push, bus.pop})
      2'b10: begin
        ptr_inc_s = 1'b1;
        wr_en_s   = 1'b1;
        wr_idx_s  = wp_s;
        if (full_s) begin
          ovf_set_s = 1'b1;
          count_d   = count_q;
        end else begin
          ovf_set_s = 1'b0;
          count_d   = count_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (empty_s) begin
          udf_set_s = 1'b1;
        end else begin
          ptr_dec_s = 1'b1;
          count_d   = count_q - CNT_W'(1);
        end
      end
      2'b11: begin
        // A tail call on a non-empty stack rewrites the top in place, even when the stack is full.
        wr_en_s = 1'b1;
        if (empty_s) begin
          ptr_inc_s = 1'b1;
          wr_idx_s  = wp_s;
          count_d   = CNT_W'(1);
          udf_set_s = 1'b1;
        end else begin
          wr_idx_s  = wp_m1_s;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    overflow_d  = (overflow_q  & ~bus.clr_err) | ovf_set_s;
    underflow_d = (underflow_q & ~bus.clr_err) | udf_set_s;
  end

  // Next array contents
  always_comb begin
    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[wr_idx_s] = bus.push_addr;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage is unreset; the zero count is what hides stale contents after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Occupancy and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= {CNT_W{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.top_addr  = empty_s ? {ADDR_W{1'b0}} : mem_q[wp_m1_s];
  assign bus.empty     = empty_s;
  assign bus.full      = full_s;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed and random checks of pc_return_stack against a queue-based LIFO model.
module tb_pc_return_stack;

  localparam int AW = 11;
  localparam int DP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [AW-1:0] q [$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  pc_return_stack_if #(.ADDR_W(AW), .DEPTH(DP)) bus ();

  pc_return_stack #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] et;
    et = (q.size() == 0) ? 11'h000 : q[q.size()-1];
    chk({tag, ".top"},   32'(bus.top_addr),  32'(et));
    chk({tag, ".count"}, 32'(bus.count),     32'(q.size()));
    chk({tag, ".empty"}, 32'(bus.empty),     32'(q.size() == 0));
    chk({tag, ".full"},  32'(bus.full),      32'(q.size() == DP));
    chk({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
    chk({tag, ".udf"},   32'(bus.underflow), 32'(m_udf));
  endtask

  // LIFO of at most DP entries; an overflowing push drops the oldest entry.
  task automatic model(input logic p, input logic [AW-1:0] a, input logic o, input logic c);
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (p && o) begin
      if (q.size() == 0) begin
        q.push_back(a);
        m_udf = 1'b1;
      end else begin
        q[q.size()-1] = a;
      end
    end else if (p) begin
      if (q.size() == DP) begin
        void'(q.pop_front());
        m_ovf = 1'b1;
      end
      q.push_back(a);
    end else if (o) begin
      if (q.size() == 0) m_udf = 1'b1;
      else void'(q.pop_back());
    end
  endtask

  task automatic step(input logic p, input logic [AW-1:0] a, input logic o, input logic c);
    bus.push      = p;
    bus.push_addr = a;
    bus.pop       = o;
    bus.clr_err   = c;
    @(posedge clk);
    #1;
    model(p, a, o, c);
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    bus.push      = 1'b0;
    bus.push_addr = 11'h000;
    bus.pop       = 1'b0;
    bus.clr_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    #4;

    step(1'b1, 11'h123, 1'b0, 1'b0);
    check_all("push123");
    chk("push123.const", 32'(bus.top_addr), 32'h123);
    step(1'b0, 11'h000, 1'b1, 1'b0);
    check_all("pop123");

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 11'(i), 1'b0, 1'b0);
    end
    check_all("fill");
    chk("fill.full", 32'(bus.full), 32'h1);
    step(1'b1, 11'h009, 1'b0, 1'b0);
    check_all("ovf");
    chk("ovf.const", 32'(bus.overflow), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("drain.top", 32'(bus.top_addr), 32'(9 - i));
      step(1'b0, 11'h000, 1'b1, 1'b0);
    end
    check_all("drained");

    step(1'b0, 11'h000, 1'b1, 1'b0);
    check_all("udf");
    chk("udf.const", 32'(bus.underflow), 32'h1);
    step(1'b0, 11'h000, 1'b0, 1'b1);
    check_all("clr");
    step(1'b0, 11'h000, 1'b1, 1'b1);
    check_all("clr_vs_set");
    chk("clr_vs_set.const", 32'(bus.underflow), 32'h1);
    step(1'b0, 11'h000, 1'b0, 1'b1);

    step(1'b1, 11'h010, 1'b0, 1'b0);
    step(1'b1, 11'h020, 1'b0, 1'b0);
    step(1'b1, 11'h7FF, 1'b1, 1'b0);
    check_all("tail");
    chk("tail.const", 32'(bus.top_addr), 32'h7FF);
    step(1'b0, 11'h000, 1'b1, 1'b0);
    check_all("tail_pop");
    chk("tail_pop.const", 32'(bus.top_addr), 32'h010);
    step(1'b0, 11'h000, 1'b1, 1'b0);

    step(1'b1, 11'h055, 1'b1, 1'b0);
    check_all("pushpop_empty");
    step(1'b0, 11'h000, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 11'(16'h0100 + i), 1'b0, 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_all("async_rst");
    #1;
    rst = 1'b0;
    step(1'b1, 11'h3AA, 1'b0, 1'b0);
    check_all("post_rst");
    chk("post_rst.const", 32'(bus.top_addr), 32'h3AA);

    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 9) < 6), 11'($urandom), 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 9) == 0));
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
